// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the load/store unit.
// Contents: funct3 codes, LSU state encoding, op legality helpers.
package riscv_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_funct3_e;

    // Store codes share encodings with the signed loads.
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

    function automatic logic f3_legal(
        input logic       we,
        input logic [2:0] f3
    );
        logic ok;
        if (we)
            ok = !f3[2] && (f3[1:0] != 2'b11);
        else
            ok = (f3[1:0] != 2'b11) &&
                 !(f3[2] && f3[1]);
        return ok;
    endfunction

    // Size is in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic f3_misalign(
        input logic [2:0] f3,
        input logic [1:0] k
    );
        logic bad;
        case (f3[1:0])
            2'b01:   bad = k[0];
            2'b10:   bad = (k != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / data steering
// and load lane extraction with sign or zero extension.
// Ports: funct3, k (addr[1:0]), wdata, rdata -> be, lane_wdata, load_data.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  k,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] sh;
    logic        uns;

    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        load_data  = 32'h0;
        uns        = funct3[2];
        // Bring the addressed lane down to bits [15:0].
        sh         = rdata >> {k, 3'b000};
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << k;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = uns ?
                    {24'h0, sh[7:0]} :
                    {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                be         = 4'b0011 << k;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = uns ?
                    {16'h0, sh[15:0]} :
                    {{16{sh[15]}}, sh[15:0]};
            end
            2'b10: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                load_data  = rdata;
            end
            default: begin
                be         = 4'b0000;
                lane_wdata = 32'h0;
                load_data  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit, initiator side of the data-memory bus.
// One outstanding access; req_ready is high only in IDLE.
// Ports: clk, rst; req_* from EX; resp_* completion pulse;
// mem_* request/grant/read-data to data memory.
// Option: define LSU_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES.
module lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        resp_misalign,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [1:0]  op_k;

    logic [2:0]  al_f3;
    logic [1:0]  al_k;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    logic        acc;
    logic        legal;
    logic        misal;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST =
        8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt;
`endif

    // In IDLE the aligner sees the incoming op (store
    // steering); afterwards it sees the latched op (load
    // extraction in WAIT).
    assign al_f3 = (state == IDLE) ? req_funct3 : op_f3;
    assign al_k  = (state == IDLE) ? req_addr[1:0] : op_k;

    assign acc   = req_valid && req_ready;
    assign legal = f3_legal(req_we, req_funct3);
    assign misal = f3_misalign(req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3     (al_f3),
        .k          (al_k),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= 32'h0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'h0;
            mem_be        <= 4'b0000;
            mem_wdata     <= 32'h0;
            op_we         <= 1'b0;
            op_f3         <= 3'b000;
            op_k          <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt           <= 8'h0;
`endif
        end else begin
            // resp_* are single-cycle unless set below.
            resp_valid    <= 1'b0;
            resp_data     <= 32'h0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        req_ready <= 1'b0;
                        op_we     <= req_we;
                        op_f3     <= req_funct3;
                        op_k      <= req_addr[1:0];
                        if (!legal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (misal) begin
                            state         <= RESP;
                            resp_valid    <= 1'b1;
                            resp_err      <= 1'b1;
                            resp_misalign <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2],
                                          2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= req_we ?
                                         al_wdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                        if (op_we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
`ifdef LSU_TIMEOUT_EN
                            cnt   <= 8'h0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= al_load;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt == TMO_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: vector table plus
// grant-delay, reset-in-WAIT and WAIT-hold/timeout sequences.
module tb_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_misalign;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .resp_misalign (resp_misalign),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    task automatic check(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h",
                     nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_mis;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic issue(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    initial begin
        int          nreq;
        int          nresp;
        int          lat;
        int          elat;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_be;
        logic        c_we;
        logic [31:0] c_data;
        logic        c_err;
        logic        c_mis;

        vt[0]  = '{1'b1, SW,  32'h100, 32'hDEADBEEF, 32'h0,
                   32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,
                   1'b0, 1'b0};
        vt[1]  = '{1'b1, SB,  32'h103, 32'h000000AB, 32'h0,
                   32'h100, 4'b1000, 32'hABABABAB, 32'h0,
                   1'b0, 1'b0};
        vt[2]  = '{1'b1, SH,  32'h102, 32'h55551234, 32'h0,
                   32'h100, 4'b1100, 32'h12341234, 32'h0,
                   1'b0, 1'b0};
        vt[3]  = '{1'b0, LB,  32'h102, 32'h0, 32'h00800000,
                   32'h100, 4'b0100, 32'h0, 32'hFFFFFF80,
                   1'b0, 1'b0};
        vt[4]  = '{1'b0, LBU, 32'h102, 32'h0, 32'h00800000,
                   32'h100, 4'b0100, 32'h0, 32'h00000080,
                   1'b0, 1'b0};
        vt[5]  = '{1'b0, LH,  32'h102, 32'h0, 32'h00800000,
                   32'h100, 4'b1100, 32'h0, 32'h00000080,
                   1'b0, 1'b0};
        vt[6]  = '{1'b0, LHU, 32'h200, 32'h0, 32'h1234F00D,
                   32'h200, 4'b0011, 32'h0, 32'h0000F00D,
                   1'b0, 1'b0};
        vt[7]  = '{1'b0, LH,  32'h200, 32'h0, 32'h1234F00D,
                   32'h200, 4'b0011, 32'h0, 32'hFFFFF00D,
                   1'b0, 1'b0};
        vt[8]  = '{1'b0, LW,  32'h104, 32'h0, 32'hCAFEBABE,
                   32'h104, 4'b1111, 32'h0, 32'hCAFEBABE,
                   1'b0, 1'b0};
        vt[9]  = '{1'b0, LB,  32'h307, 32'h0, 32'h7F000000,
                   32'h304, 4'b1000, 32'h0, 32'h0000007F,
                   1'b0, 1'b0};
        vt[10] = '{1'b0, LH,  32'h101, 32'h0, 32'h12345678,
                   32'h0, 4'b0000, 32'h0, 32'h0,
                   1'b1, 1'b1};
        vt[11] = '{1'b1, SW,  32'h102, 32'h11111111, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0,
                   1'b1, 1'b1};
        vt[12] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h12345678,
                   32'h0, 4'b0000, 32'h0, 32'h0,
                   1'b1, 1'b0};
        vt[13] = '{1'b1, 3'b100, 32'h100, 32'h22, 32'h0,
                   32'h0, 4'b0000, 32'h0, 32'h0,
                   1'b1, 1'b0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rvalid", {31'h0, resp_valid}, 32'h0);
        check("rst_mreq", {31'h0, mem_req}, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_mbe", {28'h0, mem_be}, 32'h0);
        rst = 1'b0;

        // Zero-wait memory: gnt and rvalid held high.
        for (int i = 0; i < NV; i++) begin
            mem_rdata = vt[i].rdata;
            check($sformatf("v%0d_rdy", i),
                  {31'h0, req_ready}, 32'h1);
            issue(vt[i].we, vt[i].f3, vt[i].addr,
                  vt[i].wdata);
            nreq = 0; nresp = 0; lat = 0;
            c_addr = 0; c_wdata = 0; c_be = 0; c_we = 0;
            c_data = 0; c_err = 0; c_mis = 0;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if (n == 1)
                    check($sformatf("v%0d_busy", i),
                          {31'h0, req_ready}, 32'h0);
                if (mem_req) begin
                    nreq++;
                    c_addr = mem_addr; c_be = mem_be;
                    c_wdata = mem_wdata; c_we = mem_we;
                end
                if (resp_valid) begin
                    nresp++;
                    if (lat == 0) lat = n;
                    c_data = resp_data; c_err = resp_err;
                    c_mis = resp_misalign;
                end
            end
            elat = vt[i].e_err ? 1 : (vt[i].we ? 2 : 3);
            check($sformatf("v%0d_lat", i), lat, elat);
            check($sformatf("v%0d_nresp", i), nresp, 1);
            check($sformatf("v%0d_nreq", i), nreq,
                  vt[i].e_err ? 0 : 1);
            check($sformatf("v%0d_err", i),
                  {31'h0, c_err}, {31'h0, vt[i].e_err});
            check($sformatf("v%0d_mis", i),
                  {31'h0, c_mis}, {31'h0, vt[i].e_mis});
            check($sformatf("v%0d_data", i),
                  c_data, vt[i].e_data);
            if (!vt[i].e_err) begin
                check($sformatf("v%0d_addr", i),
                      c_addr, vt[i].e_addr);
                check($sformatf("v%0d_be", i),
                      {28'h0, c_be}, {28'h0, vt[i].e_be});
                check($sformatf("v%0d_we", i),
                      {31'h0, c_we}, {31'h0, vt[i].we});
                if (vt[i].we)
                    check($sformatf("v%0d_wdata", i),
                          c_wdata, vt[i].e_wdata);
            end
        end

        // Grant held off: request must stay stable 4 cycles.
        mem_gnt = 1'b0;
        issue(1'b1, SW, 32'h208, 32'h11223344);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check($sformatf("gd%0d_req", n),
                  {31'h0, mem_req}, 32'h1);
            check($sformatf("gd%0d_addr", n),
                  mem_addr, 32'h208);
            check($sformatf("gd%0d_be", n),
                  {28'h0, mem_be}, 32'hF);
            check($sformatf("gd%0d_wd", n),
                  mem_wdata, 32'h11223344);
            check($sformatf("gd%0d_rdy", n),
                  {31'h0, req_ready}, 32'h0);
            check($sformatf("gd%0d_rv", n),
                  {31'h0, resp_valid}, 32'h0);
            if (n == 4) mem_gnt = 1'b1;
        end
        nresp = 0; lat = 0;
        for (int n = 5; n <= 10; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (lat == 0) lat = n;
            end
        end
        check("gd_lat", lat, 5);
        check("gd_nresp", nresp, 1);

        // Reset while in WAIT, then a late rvalid.
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hA5A5A5A5;
        issue(1'b0, LW, 32'h300, 32'h0);
        repeat (3) @(negedge clk);
        check("rw_wait_rv", {31'h0, resp_valid}, 32'h0);
        check("rw_wait_rdy", {31'h0, req_ready}, 32'h0);
        rst = 1'b1;
        #1;
        check("rw_abort_rdy", {31'h0, req_ready}, 32'h1);
        check("rw_abort_mreq", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        nresp = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("rw_late_nresp", nresp, 0);
        check("rw_idle_rdy", {31'h0, req_ready}, 32'h1);

        // No rvalid: timeout build errors after 8 WAIT
        // cycles, default build waits for rvalid.
        mem_rvalid = 1'b0;
        issue(1'b0, LW, 32'h400, 32'h0);
        nresp = 0; lat = 0; c_err = 0; c_mis = 0;
        c_data = 32'hFFFFFFFF;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (lat == 0) lat = n;
                c_err = resp_err; c_mis = resp_misalign;
                c_data = resp_data;
            end
        end
`ifdef LSU_TIMEOUT_EN
        check("to_lat", lat, 10);
        check("to_nresp", nresp, 1);
        check("to_err", {31'h0, c_err}, 32'h1);
        check("to_mis", {31'h0, c_mis}, 32'h0);
        check("to_data", c_data, 32'h0);
`else
        check("hold_nresp", nresp, 0);
        check("hold_rdy", {31'h0, req_ready}, 32'h0);
        mem_rdata  = 32'h0000BEEF;
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("hold_rv", {31'h0, resp_valid}, 32'h1);
        check("hold_data", resp_data, 32'h0000BEEF);
        check("hold_err", {31'h0, resp_err}, 32'h0);
        @(negedge clk);
        check("hold_rv_end", {31'h0, resp_valid}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
